// File: rtl/wg_pkg.sv
// Shared WorldGuard definitions.
//   wg_switch_state_e : phases of a WID switch (IDLE, DRAIN, COMMIT).
//   wid_legal()       : true when a WID is implemented and permitted by the mask.
package wg_pkg;

  // Upper bound on the world mask width accepted by wid_legal().
  localparam int unsigned WG_MAX_WORLDS = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } wg_switch_state_e;

  // A WID is legal when it names an implemented world whose mask bit is set.
  function automatic logic wid_legal(
    input int unsigned                wid,
    input int unsigned                n_worlds,
    input logic [WG_MAX_WORLDS-1:0]   mwid_list
  );
    logic legal;
    legal = 1'b0;
    if ((wid < n_worlds) && (wid < WG_MAX_WORLDS)) begin
      legal = mwid_list[wid[7:0]];
    end
    return legal;
  endfunction

endpackage

// File: rtl/wg_txn_counter.sv
// Up/down counter of in-flight memory transactions.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   inc_i          : one transaction issued this cycle
//   dec_i          : one transaction completed this cycle
//   count_o        : registered count
//   count_next_o   : count after this cycle's inc/dec (combinational)
//   full_o         : count == MaxTx
//   empty_o        : count == 0
// The count saturates at 0 and MaxTx; hitting either bound raises a warning.
module wg_txn_counter #(
  parameter int unsigned MaxTx = 8,
  parameter int unsigned CntW  = $clog2(MaxTx + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o,
  output logic [CntW-1:0] count_next_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  assign full_o  = (count_q == CntW'(MaxTx));
  assign empty_o = (count_q == '0);

  // Simultaneous inc and dec cancel out, even at either bound.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o) begin
      count_d = count_q + CntW'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(dec_i && !inc_i && empty_o))
        else $warning("wg_txn_counter: completion with no transaction outstanding");
      assert (!(inc_i && !dec_i && full_o))
        else $warning("wg_txn_counter: issue with counter already at MaxTx");
    end
  end

endmodule

// File: rtl/wg_wid_switch_ctrl.sv
// Sequences a change of the active WorldGuard WID: a CSR write blocks new
// memory issue, waits for in-flight transactions to drain, then commits the
// new WID so no request is ever tagged with a mix of worlds.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   wid_wr_en_i/data_i  : CSR write request (held until wid_wr_ready_o)
//   wid_wr_ready_o      : write accepted this cycle when also enabled
//   wid_illegal_o       : one-cycle pulse after a rejected write
//   mem_req_fire_i      : memory request issued this cycle
//   mem_rsp_fire_i      : memory transaction completed this cycle
//   mem_req_gate_o      : upstream must not issue while high
//   wid_o               : active WID
//   outstanding_o       : in-flight transaction count
//   busy_o              : switch in progress
module wg_wid_switch_ctrl
  import wg_pkg::*;
#(
  parameter int unsigned                WidWidth = 4,
  parameter int unsigned                NWorlds  = 16,
  parameter logic [NWorlds-1:0]         MwidList = 16'hFFFF,
  parameter logic [WidWidth-1:0]        RstWid   = '0,
  parameter int unsigned                MaxTx    = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wid_wr_en_i,
  input  logic [WidWidth-1:0]          wid_wr_data_i,
  output logic                         wid_wr_ready_o,
  output logic                         wid_illegal_o,
  input  logic                         mem_req_fire_i,
  input  logic                         mem_rsp_fire_i,
  output logic                         mem_req_gate_o,
  output logic [WidWidth-1:0]          wid_o,
  output logic [$clog2(MaxTx+1)-1:0]   outstanding_o,
  output logic                         busy_o
);

  localparam int unsigned CntW = $clog2(MaxTx + 1);

  wg_switch_state_e      state_q, state_d;
  logic [WidWidth-1:0]   wid_q, wid_d;
  logic [WidWidth-1:0]   pending_q, pending_d;
  logic                  illegal_q, illegal_d;

  logic [CntW-1:0]       cnt;
  logic [CntW-1:0]       cnt_next;
  logic                  cnt_full;
  logic                  cnt_empty_unused;
  logic                  wr_legal;

  // Fires are counted even when they violate the gate, so the drain still
  // waits for their responses.
  wg_txn_counter #(
    .MaxTx (MaxTx),
    .CntW  (CntW)
  ) u_txn_counter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inc_i        (mem_req_fire_i),
    .dec_i        (mem_rsp_fire_i),
    .count_o      (cnt),
    .count_next_o (cnt_next),
    .full_o       (cnt_full),
    .empty_o      (cnt_empty_unused)
  );

  assign wr_legal = wid_legal(32'(wid_wr_data_i), NWorlds, WG_MAX_WORLDS'(MwidList));

  always_comb begin
    state_d   = state_q;
    wid_d     = wid_q;
    pending_d = pending_q;
    illegal_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wid_wr_en_i) begin
          if (!wr_legal) begin
            illegal_d = 1'b1;
          end else if (wid_wr_data_i != wid_q) begin
            pending_d = wid_wr_data_i;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Look at the next count so a response in this cycle finishes the drain.
        if (cnt_next == '0) begin
          wid_d   = pending_q;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wid_q     <= RstWid;
      pending_q <= RstWid;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wid_q     <= wid_d;
      pending_q <= pending_d;
      illegal_q <= illegal_d;
    end
  end

  assign wid_wr_ready_o = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign mem_req_gate_o = (state_q != IDLE) || cnt_full;
  assign wid_illegal_o  = illegal_q;
  assign wid_o          = wid_q;
  assign outstanding_o  = cnt;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(mem_req_fire_i && mem_req_gate_o))
        else $warning("wg_wid_switch_ctrl: memory request issued while gated");
    end
  end

endmodule

// File: tb/tb_wg_wid_switch_ctrl.sv
module tb_wg_wid_switch_ctrl;

  localparam int MAXTX = 8;
  localparam logic [15:0] MASK = 16'h00FF;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic       illegal;
  logic       fire;
  logic       rsp;
  logic       gate;
  logic [3:0] wid;
  logic [3:0] outstanding;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  wg_wid_switch_ctrl #(
    .WidWidth (4),
    .NWorlds  (16),
    .MwidList (MASK),
    .RstWid   (4'd0),
    .MaxTx    (MAXTX)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wid_wr_en_i    (wr_en),
    .wid_wr_data_i  (wr_data),
    .wid_wr_ready_o (wr_ready),
    .wid_illegal_o  (illegal),
    .mem_req_fire_i (fire),
    .mem_rsp_fire_i (rsp),
    .mem_req_gate_o (gate),
    .wid_o          (wid),
    .outstanding_o  (outstanding),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {wid, outstanding, gate, ready, illegal, busy}
  function automatic logic [11:0] pack(input logic [3:0] w, input logic [3:0] c,
                                       input logic g, input logic r,
                                       input logic i, input logic b);
    return {w, c, g, r, i, b};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = pack(wid, outstanding, gate, wr_ready, illegal, busy);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got wid=%0d cnt=%0d gate=%0b rdy=%0b ill=%0b busy=%0b, want wid=%0d cnt=%0d gate=%0b rdy=%0b ill=%0b busy=%0b",
               name, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s: wid=%0d cnt=%0d gate=%0b rdy=%0b ill=%0b busy=%0b",
               name, act[11:8], act[7:4], act[3], act[2], act[1], act[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0; wr_data = '0; fire = 1'b0; rsp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  // Directed table: inputs applied in a cycle, expected outputs of that same cycle.
  typedef struct {
    string      name;
    logic       en;
    logic [3:0] data;
    logic       f;
    logic       r;
    logic [3:0] e_wid;
    logic [3:0] e_cnt;
    logic       e_gate;
    logic       e_rdy;
    logic       e_ill;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input string n, input logic en, input logic [3:0] d,
                             input logic f, input logic r, input logic [3:0] w,
                             input logic [3:0] c, input logic g, input logic rd,
                             input logic il, input logic b);
    vec_t t;
    t.name = n; t.en = en; t.data = d; t.f = f; t.r = r;
    t.e_wid = w; t.e_cnt = c; t.e_gate = g; t.e_rdy = rd; t.e_ill = il; t.e_busy = b;
    return t;
  endfunction

  // Reference model: a switch is "draining toward target" or "committing";
  // counter follows issue-minus-completion with saturation.
  int m_wid, m_cnt, m_target;
  bit m_drain, m_commit, m_ill;

  function automatic bit m_legal(input int d);
    logic [15:0] mk;
    mk = MASK;
    return (d < 16) && (mk[d] == 1'b1);
  endfunction

  task automatic model_reset();
    m_wid = 0; m_cnt = 0; m_target = 0;
    m_drain = 0; m_commit = 0; m_ill = 0;
  endtask

  function automatic logic [11:0] model_out();
    bit bsy;
    bsy = m_drain || m_commit;
    return pack(4'(m_wid), 4'(m_cnt), bsy || (m_cnt == MAXTX), !bsy, m_ill, bsy);
  endfunction

  task automatic model_step(input bit en, input int d, input bit f, input bit r);
    int nc;
    bit was_idle;
    was_idle = !(m_drain || m_commit);
    nc = m_cnt;
    if (f && !r && m_cnt < MAXTX) nc = m_cnt + 1;
    if (r && !f && m_cnt > 0)     nc = m_cnt - 1;
    m_ill = 0;
    if (m_commit) m_commit = 0;
    if (m_drain && nc == 0) begin
      m_wid = m_target; m_drain = 0; m_commit = 1;
    end
    if (was_idle && en) begin
      if (!m_legal(d)) m_ill = 1;
      else if (d != m_wid) begin m_target = d; m_drain = 1; end
    end
    m_cnt = nc;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_data = '0; fire = 1'b0; rsp = 1'b0;
    #2;
    check("reset_async", pack(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    do_reset();
    check("reset_state", pack(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));

    //                name          en d  f r   wid cnt g rdy ill busy
    tbl.push_back(v("sw3_c0",      1, 3, 0,0,  0, 0, 0,1,0,0));
    tbl.push_back(v("sw3_c1",      0, 0, 0,0,  0, 0, 1,0,0,1));
    tbl.push_back(v("sw3_c2",      0, 0, 0,0,  3, 0, 1,0,0,1));
    tbl.push_back(v("sw3_c3",      0, 0, 0,0,  3, 0, 0,1,0,0));
    tbl.push_back(v("ill9_wr",     1, 9, 0,0,  3, 0, 0,1,0,0));
    tbl.push_back(v("ill9_pulse",  0, 0, 0,0,  3, 0, 0,1,1,0));
    tbl.push_back(v("ill9_after",  0, 0, 0,0,  3, 0, 0,1,0,0));
    tbl.push_back(v("same3_wr",    1, 3, 0,0,  3, 0, 0,1,0,0));
    tbl.push_back(v("same3_after", 0, 0, 0,0,  3, 0, 0,1,0,0));
    tbl.push_back(v("tr_fire0",    0, 0, 1,0,  3, 0, 0,1,0,0));
    tbl.push_back(v("tr_fire1",    0, 0, 1,0,  3, 1, 0,1,0,0));
    tbl.push_back(v("tr_wr5",      1, 5, 0,0,  3, 2, 0,1,0,0));
    tbl.push_back(v("tr_p1",       0, 0, 0,0,  3, 2, 1,0,0,1));
    tbl.push_back(v("tr_p2",       0, 0, 0,0,  3, 2, 1,0,0,1));
    tbl.push_back(v("tr_p3",       0, 0, 0,0,  3, 2, 1,0,0,1));
    tbl.push_back(v("tr_p4_rsp",   0, 0, 0,1,  3, 2, 1,0,0,1));
    tbl.push_back(v("tr_p5",       0, 0, 0,0,  3, 1, 1,0,0,1));
    tbl.push_back(v("tr_p6",       0, 0, 0,0,  3, 1, 1,0,0,1));
    tbl.push_back(v("tr_p7_rsp",   0, 0, 0,1,  3, 1, 1,0,0,1));
    tbl.push_back(v("tr_p8",       0, 0, 0,0,  5, 0, 1,0,0,1));
    tbl.push_back(v("tr_p9",       0, 0, 0,0,  5, 0, 0,1,0,0));
    for (int i = 0; i < MAXTX; i++)
      tbl.push_back(v("bnd_fill",  0, 0, 1,0,  5, 4'(i), 0,1,0,0));
    tbl.push_back(v("bnd_fr_at8",  0, 0, 1,1,  5, 8, 1,1,0,0));
    tbl.push_back(v("bnd_hold8",   0, 0, 0,0,  5, 8, 1,1,0,0));
    for (int i = MAXTX; i > 0; i--)
      tbl.push_back(v("bnd_drain", 0, 0, 0,1,  5, 4'(i), (i == MAXTX),1,0,0));
    tbl.push_back(v("bnd_rsp_at0", 0, 0, 0,1,  5, 0, 0,1,0,0));
    tbl.push_back(v("bnd_hold0",   0, 0, 0,0,  5, 0, 0,1,0,0));

    foreach (tbl[i]) begin
      wr_en = tbl[i].en; wr_data = tbl[i].data; fire = tbl[i].f; rsp = tbl[i].r;
      check(tbl[i].name, pack(tbl[i].e_wid, tbl[i].e_cnt, tbl[i].e_gate,
                              tbl[i].e_rdy, tbl[i].e_ill, tbl[i].e_busy));
      tick();
    end
    wr_en = 0; fire = 0; rsp = 0;

    // Reset in the middle of a drain with three transactions outstanding.
    do_reset();
    fire = 1; tick(); tick(); tick();
    fire = 0; wr_en = 1; wr_data = 4'd6; tick();
    wr_en = 0; tick();
    check("mid_drain", pack(4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1));
    #2 rst = 1'b1;
    #1 check("mid_drain_rst", pack(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); rst = 1'b0; #1;
    check("after_rst", pack(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));

    // Randomized traffic and switch requests against the model.
    do_reset();
    model_reset();
    begin
      bit req;
      req = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        logic [11:0] exp;
        exp = model_out();
        if (!req && ($urandom_range(0, 7) == 0)) begin
          req = 1; wr_data = 4'($urandom_range(0, 15));
        end
        wr_en = req;
        fire  = !exp[3] && ($urandom_range(0, 2) == 0);
        rsp   = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
        check($sformatf("rand_%0d", cyc), exp);
        if (req && exp[2]) req = 0;
        model_step(wr_en, int'(wr_data), fire, rsp);
        tick();
      end
    end
    wr_en = 0; fire = 0; rsp = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wg_wid_switch_ctrl.md
Name: wg_wid_switch_ctrl

Overview:
- Sequences a change of the active WorldGuard world ID (WID) that tags every outgoing memory request from the core.
- On a WID CSR write, it blocks new memory issue, drains the in-flight transactions, then commits the new WID. Traffic is therefore never tagged with a mix of worlds.
- Sits between the CSR file and the cache/bus request path. It is configured from cfg.WG_ID_WIDTH, cfg.WG_N_WORLDS, cfg.WG_MWID_LIST, cfg.WG_ID_RST_VALUE and cfg.DCACHE_MAX_TX.

Parameters:
- WidWidth, 4, width of the WID (cfg.WG_ID_WIDTH).
- NWorlds, 16, number of implemented worlds (cfg.WG_N_WORLDS).
- MwidList, 16'hFFFF, NWorlds-bit mask of permitted WIDs (cfg.WG_MWID_LIST).
- RstWid, 0, WID value at reset (cfg.WG_ID_RST_VALUE).
- MaxTx, 8, maximum outstanding memory transactions (cfg.DCACHE_MAX_TX).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- wid_wr_en_i  in  1  CSR write request; held until accepted.
- wid_wr_data_i  in  WidWidth  requested WID.
- wid_wr_ready_o  out  1  write accepted when wid_wr_en_i && wid_wr_ready_o.
- wid_illegal_o  out  1  one-cycle pulse: write rejected.
- mem_req_fire_i  in  1  a memory request issued this cycle.
- mem_rsp_fire_i  in  1  a memory transaction completed this cycle.
- mem_req_gate_o  out  1  upstream must not issue while high.
- wid_o  out  WidWidth  active WID applied to requests.
- outstanding_o  out  $clog2(MaxTx+1)  in-flight transaction count.
- busy_o  out  1  switch in progress (state != IDLE).

Behaviour:
- Reset values:
  - state IDLE, wid_o=RstWid, outstanding_o=0.
  - wid_wr_ready_o=1, wid_illegal_o=0, mem_req_gate_o=0, busy_o=0.
  - The pending WID is discarded.
- Reset asserted mid-switch aborts the switch: wid_o returns to RstWid.
- Outstanding counter (outstanding_q):
  - next = q + fire - rsp. Fire and rsp in the same cycle hold the count.
  - rsp at count 0: counter holds at 0; assertion fires.
  - fire at count MaxTx: counter holds; assertion fires.
  - fire while mem_req_gate_o=1 is a protocol violation: assertion fires, but the fire is still counted.
- mem_req_gate_o = (state != IDLE) || (outstanding_q == MaxTx). It is combinational from registers only.
- wid_wr_ready_o = (state == IDLE).
- FSM, IDLE (accepted write):
  - Data >= NWorlds or MwidList[data]==0: wid_illegal_o pulses in the next cycle; no state change.
  - Data == wid_o: accepted as a no-op; no gate, no pulse.
  - Otherwise: pending_q <= data; go to DRAIN.
  - A fire in the same cycle as the write is legal (gate is still 0) and is counted.
- FSM, DRAIN: gate=1. When the counter's next value == 0: wid_o <= pending_q; go to COMMIT. A rsp in the same cycle counts toward the drain.
- FSM, COMMIT: gate=1 for exactly one cycle with the new wid_o stable, then go to IDLE.
- Minimum latency with nothing outstanding:
  - Write accepted in cycle 0.
  - Gate high in cycles 1–2.
  - wid_o new from cycle 2.
  - Gate low and ready high in cycle 3.
- With N outstanding, DRAIN lasts until the last rsp. There is no timeout.
- While not ready, wid_wr_en_i is not accepted; the requester holds the request.

Decomposition:
- Shared package wg_pkg:
  - wg_switch_state_e (IDLE, DRAIN, COMMIT).
  - A function wid_legal(wid, NWorlds, MwidList).
- Sub-module wg_txn_counter: up/down outstanding counter with full/empty flags and saturation assertions. It is reused by the load/store units.
- The top-level block holds the FSM and the WID register.

Test Plan:
- Legal switch, idle bus. Reset, then write 3 with count 0 → gate high cycles 1–2, wid_o=3 from cycle 2, ready=1 in cycle 3, no illegal pulse.
- Drain with traffic.
  - Stimulus: 2 fires issued; write 5; rsps at cycle +4 and +7.
  - Required: gate held through cycle +7, wid_o=5 at cycle +8, outstanding_o back to 0.
- Illegal WID rejected.
  - Stimulus: MwidList=16'h00FF, write 9.
  - Required: wid_illegal_o=1 for one cycle; wid_o and gate unchanged.
- Same WID is a no-op. Write equal to the current wid_o → accepted, gate never rises, busy_o stays 0.
- Boundary counts.
  - Stimulus: MaxTx fires issued.
  - Required: gate=1 at count 8; a simultaneous fire+rsp at count 8 holds 8; a rsp at 0 holds 0 and trips the assertion.
- Reset mid-DRAIN. Assert rst_i during DRAIN with count 3 → wid_o=RstWid, count 0, state IDLE, gate 0 immediately (async).
